// File: rtl/dff_bank_arbiter_pkg.sv
// Shared types and defaults for the round-robin shared-register write arbiter.
package dff_bank_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StAck
  } arb_state_e;

  localparam int unsigned DefaultN        = 4;
  localparam int unsigned DefaultW        = 8;
  localparam int unsigned DefaultBurstMax = 4;

  // Width of a requester index; never zero so a 1-requester build stays legal.
  function automatic int unsigned owner_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dff_en_reg.sv
// W-bit D flip-flop register with load enable and asynchronous active-high reset.
module dff_en_reg #(
  parameter int unsigned    W         = 8,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         async_reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      r_q <= RESET_VAL;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter in front of a shared W-bit register.
// Optional burst mode: define ARB_BURST_EN to allow up to BURST_MAX writes per grant.
module dff_bank_arbiter
  import dff_bank_arbiter_pkg::*;
#(
  parameter int unsigned  N         = DefaultN,
  parameter int unsigned  W         = DefaultW,
  parameter logic [W-1:0] RESET_VAL = '0,
  parameter int unsigned  BURST_MAX = DefaultBurstMax
) (
  input  logic                  clk,
  input  logic                  async_reset,
  input  logic [N-1:0]          req,
  input  logic [N*W-1:0]        wr_data,
  output logic [N-1:0]          grant,
  output logic [N-1:0]          ack,
  output logic [owner_w(N)-1:0] owner,
  output logic                  busy,
  output logic [W-1:0]          reg_q
);

  localparam int unsigned OW = owner_w(N);

  arb_state_e    r_state;
  logic [N-1:0]  r_grant;
  logic [N-1:0]  r_ack;
  logic [OW-1:0] r_owner;
  logic [OW-1:0] r_last_owner;
  logic          r_busy;

  logic          w_found;
  logic [OW-1:0] w_winner;
  logic [N-1:0]  w_owner_oh;
  logic          w_we;
  logic [W-1:0]  w_wr_sel;

`ifdef ARB_BURST_EN
  localparam int unsigned CW = $clog2(BURST_MAX + 1);
  logic [CW-1:0] r_burst_cnt;
  logic          w_burst_more;

  assign w_burst_more = req[r_owner] && (int'(r_burst_cnt) < int'(BURST_MAX) - 1);
`endif

  // Search starts just past the last grantee so it gets lowest priority.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= int'(N); k++) begin
      if (!w_found && req[(int'(r_last_owner) + k) % int'(N)]) begin
        w_found  = 1'b1;
        w_winner = OW'((int'(r_last_owner) + k) % int'(N));
      end
    end
  end

  assign w_owner_oh = {{(N-1){1'b0}}, 1'b1} << r_owner;
  assign w_we       = (r_state == StGrant);
  assign w_wr_sel   = wr_data[int'(r_owner)*W +: W];

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      r_state      <= StIdle;
      r_grant      <= '0;
      r_ack        <= '0;
      r_owner      <= '0;
      r_last_owner <= OW'(N - 1);
      r_busy       <= 1'b0;
`ifdef ARB_BURST_EN
      r_burst_cnt  <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          r_ack <= '0;
          if (w_found) begin
            r_grant <= {{(N-1){1'b0}}, 1'b1} << w_winner;
            r_owner <= w_winner;
            r_busy  <= 1'b1;
            r_state <= StGrant;
`ifdef ARB_BURST_EN
            r_burst_cnt <= '0;
`endif
          end
        end
        StGrant: begin
          r_ack   <= w_owner_oh;
          r_state <= StAck;
        end
        StAck: begin
          r_ack <= '0;
`ifdef ARB_BURST_EN
          if (w_burst_more) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
            r_state     <= StGrant;
          end else begin
            r_grant      <= '0;
            r_busy       <= 1'b0;
            r_last_owner <= r_owner;
            r_state      <= StIdle;
          end
`else
          r_grant      <= '0;
          r_busy       <= 1'b0;
          r_last_owner <= r_owner;
          r_state      <= StIdle;
`endif
        end
        default: begin
          r_grant <= '0;
          r_ack   <= '0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  dff_en_reg #(
    .W         (W),
    .RESET_VAL (RESET_VAL)
  ) u_shared_reg (
    .clk         (clk),
    .async_reset (async_reset),
    .en          (w_we),
    .d           (w_wr_sel),
    .q           (reg_q)
  );

  assign grant = r_grant;
  assign ack   = r_ack;
  assign owner = r_owner;
  assign busy  = r_busy;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Randomized bench for dff_bank_arbiter against a transaction-level round-robin model.
module tb_dff_bank_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned BM = 4;
`ifdef ARB_BURST_EN
  localparam int Writes = BM;
`else
  localparam int Writes = 1;
`endif

  logic           clk = 1'b0;
  logic           async_reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] wr_data;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;
  logic [1:0]     owner;
  logic           busy;
  logic [W-1:0]   reg_q;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: who was served last and what the shared register should hold.
  int         m_last;
  logic [7:0] m_reg;

  dff_bank_arbiter #(
    .N         (N),
    .W         (W),
    .RESET_VAL (8'h00),
    .BURST_MAX (BM)
  ) dut (
    .clk         (clk),
    .async_reset (async_reset),
    .req         (req),
    .wr_data     (wr_data),
    .grant       (grant),
    .ack         (ack),
    .owner       (owner),
    .busy        (busy),
    .reg_q       (reg_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= int'(N); k++) begin
      if (r[(last + k) % int'(N)]) return (last + k) % int'(N);
    end
    return -1;
  endfunction

  task automatic run_txn(input logic [N-1:0] r, input logic [31:0] d);
    int         w;
    logic [3:0] oh;
    logic [7:0] dv;
    req     = r;
    wr_data = d;
    w = pick(r, m_last);
    if (w < 0) begin
      tick();
      check("idle_grant", 32'(grant), 0);
      check("idle_busy", 32'(busy), 0);
      check("idle_reg", 32'(reg_q), 32'(m_reg));
      return;
    end
    oh = 4'b0001 << w;
    dv = d[w*8 +: 8];
    for (int b = 0; b < Writes; b++) begin
      tick();
      check("grant", 32'(grant), 32'(oh));
      check("grant_ack", 32'(ack), 0);
      check("busy", 32'(busy), 1);
      check("owner", 32'(owner), 32'(w));
      tick();
      check("ack", 32'(ack), 32'(oh));
      check("ack_grant", 32'(grant), 32'(oh));
      check("reg_q", 32'(reg_q), 32'(dv));
    end
    m_reg  = dv;
    m_last = w;
    req    = '0;
    tick();
    check("end_grant", 32'(grant), 0);
    check("end_ack", 32'(ack), 0);
    check("end_busy", 32'(busy), 0);
  endtask

  initial begin
    async_reset = 1'b1;
    req         = '0;
    wr_data     = '0;
    m_last      = N - 1;
    m_reg       = 8'h00;
    #12;
    check("rst_grant", 32'(grant), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_reg", 32'(reg_q), 0);
    tick();
    async_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_ack", 32'(ack), 0);
      check("post_rst_grant", 32'(grant), 0);
    end

    run_txn(4'b0001, 32'h000000A5);
    for (int i = 0; i < 5; i++) run_txn(4'b1111, 32'h44332211 + 32'(i));
    run_txn(4'b0000, 32'hFFFFFFFF);

    for (int i = 0; i < 80; i++) begin
      logic [N-1:0] r;
      r = N'($urandom_range(0, 15));
      if (i % 5 == 0) r = 4'b0001 << $urandom_range(0, 3);
      run_txn(r, $urandom);
    end

    // Reset while in GRANT: write discarded, no ack, priority back to requester 0.
    run_txn(4'b0010, 32'h00003C00);
    req     = 4'b0100;
    wr_data = 32'h00770000;
    tick();
    check("pre_rst_grant", 32'(grant), 32'(4'b0100));
    async_reset = 1'b1;
    #1;
    check("mid_rst_grant", 32'(grant), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_reg", 32'(reg_q), 0);
    req = '0;
    tick();
    check("mid_rst_ack", 32'(ack), 0);
    check("mid_rst_reg_held", 32'(reg_q), 0);
    async_reset = 1'b0;
    m_last = N - 1;
    m_reg  = 8'h00;
    tick();
    check("after_rst_ack", 32'(ack), 0);
    run_txn(4'b1111, 32'h0D0C0B0A);
    run_txn(4'b1100, 32'h87654321);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Round-robin write arbiter for a shared W-bit D flip-flop register that several requesters must update. It grants one requester at a time, commits that requester's data into the shared register through a load enable, and returns a one-cycle acknowledge. It sits between the requesting datapath blocks and the shared storage element, which it instantiates internally.

## Interface
- N, 4: number of requesters (2..8)
- W, 8: width of the shared register and of each requester's data
- RESET_VAL, 0: value of the shared register after reset
- BURST_MAX, 4: maximum consecutive writes per grant (used only with burst mode compiled in)

- clk  in  1  rising-edge clock
- async_reset  in  1  asynchronous, active-high reset
- req  in  N  per-requester write request, level
- wr_data  in  N*W  requester i data in bits [i*W +: W]
- grant  out  N  one-hot grant, registered
- ack  out  N  one-hot, one-cycle write-done pulse, registered
- owner  out  $clog2(N)  index of the current or last grantee
- busy  out  1  high in any state other than IDLE
- reg_q  out  W  shared register contents

## Operation
- FSM states: IDLE, GRANT, ACK.
- IDLE: if any req bit is set, the block picks a winner by round-robin.
  - Search starts at (last_owner+1) mod N and wraps around.
  - The block registers the one-hot grant, sets owner and moves to GRANT.
  - If no req bit is set, it stays in IDLE.
- GRANT: the internal we is high for exactly this cycle.
  - The shared register loads wr_data[owner] at the next edge.
  - Next state is ACK. A req drop during GRANT does not cancel the write.
- ACK: ack[owner] is high and grant stays high.
  - Next state is IDLE and last_owner is set to owner.
  - With burst mode, ACK can return to GRANT instead (see Configuration).
- The shared register holds its value whenever we is low.
- Fairness: a requester that has just been served has the lowest priority in the next arbitration.
- A lone requester can win back-to-back.
- Requests arriving while busy are not queued. They are seen on the next IDLE evaluation only if still asserted.
- Reset values:
  - state = IDLE
  - grant = 0, ack = 0, busy = 0, owner = 0
  - last_owner = N-1, so requester 0 has first priority
  - reg_q = RESET_VAL
- Reset mid-operation: the FSM returns to IDLE immediately.
  - A write not yet clocked in is discarded.
  - No ack is issued.

## Timing
- Edge E0 (IDLE, req seen): after E0, grant=1, busy=1, we=1.
- Edge E1: reg_q updates to the new data. After E1, ack=1.
- Edge E2: after E2, grant=0, ack=0, state=IDLE.
- Request-to-ack latency is 2 cycles. Each write occupies 3 cycles including IDLE arbitration.
- Requesters must drop req on the edge that ends the ack cycle, or be treated as requesting again.
- wr_data[i] must be stable from grant rising until the edge that ends GRANT.
- reg_q is valid in the same cycle ack is high.

## Configuration
- ARB_BURST_EN defined:
  - In ACK, if req[owner] is still high and the burst count is below BURST_MAX-1, the FSM goes to GRANT again without re-arbitration.
  - grant stays high and the burst count increments. A new write then takes 2 cycles.
  - The burst count clears on entry from IDLE.
  - When BURST_MAX is reached, the FSM goes to IDLE and arbitration proceeds normally.
- ARB_BURST_EN undefined: BURST_MAX is ignored and every grant performs exactly one write.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE, GRANT, ACK)
  - the owner index width function
  - the default W, N and BURST_MAX constants
- One sub-module, dff_en_reg: W-bit register with enable and asynchronous reset to RESET_VAL. It is the shared storage.
- The top level holds the FSM, the round-robin pointer and the burst counter.

## Test plan
- Reset, then no requests: reg_q=RESET_VAL, grant=0, busy=0. Releasing async_reset does not cause spurious ack.
- req=0001, wr_data[0]=8'hA5, req dropped after ack: grant=0001 at E0+1, ack=0001 at E1+1, reg_q=8'hA5, state back to IDLE.
- All four requesters held with distinct data: grants go 0,1,2,3,0. reg_q follows each requester's data in that order.
- async_reset asserted during GRANT: no ack, reg_q=RESET_VAL, next grant goes to requester 0.
- ARB_BURST_EN, BURST_MAX=4, req[2] held with data incrementing each write: four writes with acks spaced 2 cycles apart, then IDLE. Any pending req[3] is granted next.
- ARB_BURST_EN undefined, same stimulus: one write per arbitration, ack every 3 cycles.
